conv_mem_stream: RTL and testbench
==================================

CONV_MEM_STREAM -- requirements
Module: conv_mem_stream

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- NUM_BANKS, 5, banks; 3 weight taps, bias, shift.
- BANK_BW, 3, bank select width.
- ADDR_BW, 3, word address width; DEPTH = 2^ADDR_BW.
- VECTOR_BW, 104, bits per word.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk_i, in, 1, the single clock.
- rst_i, in, 1, reset, synchronous, active-high.
- cfg_wr_en_i, in, 1, config write strobe.
- cfg_rd_en_i, in, 1, config read strobe.
- cfg_rd_wr_bank_i, in, BANK_BW, config bank.
- cfg_rd_wr_addr_i, in, ADDR_BW, config word address.
- cfg_wr_data_i, in, VECTOR_BW, config write data.
- cfg_rd_data_o, out, VECTOR_BW, config read-back data.
- start_i, in, 1, begins one stream pass.
- busy_o, out, 1, a stream pass is in progress.
- valid_o, out, 1, stream beat valid.
- ready_i, in, 1, downstream accepts the beat.
- data_o, out, NUM_BANKS*VECTOR_BW, {bank NUM_BANKS-1 .. bank 0} at one address.
- last_o, out, 1, the beat carries address DEPTH-1.

Function
REQ-003 Storage SHALL be NUM_BANKS x DEPTH words of VECTOR_BW bits.
REQ-004 cfg_wr_en_i with bank < NUM_BANKS SHALL write the word at the next clock edge.
REQ-005 Config writes SHALL commit in every state; they are never stalled or dropped.
REQ-006 A config write with bank >= NUM_BANKS SHALL be ignored.
REQ-007 cfg_rd_en_i SHALL load cfg_rd_data_o with the addressed word one cycle later.
REQ-008 cfg_rd_data_o SHALL hold its value until the next cfg_rd_en_i.
REQ-009 A config read with bank >= NUM_BANKS SHALL return 0.
REQ-010 Memory accesses SHALL be read-first: a same-cycle read and write of one word returns the old data.
REQ-011 The FSM SHALL have two states, IDLE and STREAM.
REQ-012 In IDLE, start_i SHALL move to STREAM and clear the read pointer ptr to 0.
REQ-013 start_i SHALL be ignored in STREAM.
REQ-014 In STREAM, the output register SHALL load when the slot is free (!valid_o || ready_i) and beats remain to issue.
REQ-015 On that load: data_o = all banks at ptr, valid_o = 1, last_o = (ptr == DEPTH-1), and ptr increments.
REQ-016 A handshake SHALL occur when valid_o && ready_i.
REQ-017 The handshake that retires the beat with last_o set SHALL clear valid_o and last_o and return the FSM to IDLE.
REQ-018 First-beat latency SHALL be start_i at cycle t -> valid_o at t+1 (address 0).
REQ-019 With ready_i held high, throughput SHALL be one beat per cycle and a pass SHALL take exactly DEPTH beats.
REQ-020 While valid_o && !ready_i, data_o and last_o SHALL hold stable and ptr SHALL NOT advance.
REQ-021 ptr SHALL be ADDR_BW+1 bits wide so that "all beats issued" is distinct from wrap-around to 0.
REQ-022 busy_o SHALL be (state == STREAM).
REQ-023 For back-to-back passes, start_i in the cycle after the last handshake SHALL begin a new pass.

Reset
REQ-024 rst_i SHALL force state IDLE, ptr 0, valid_o 0, last_o 0, busy_o 0, data_o 0 and cfg_rd_data_o 0.
REQ-025 Memory contents SHALL be unaffected by rst_i.
REQ-026 rst_i asserted mid-pass SHALL abort the pass; no further beats are produced until a new start_i.

Structure
REQ-027 A shared package SHALL hold the state encoding (IDLE=0, STREAM=1) and the default conv1/conv2 geometry constants.
REQ-028 The design SHALL contain one sub-module, conv_mem_bank: one bank with a config write port, a config read port and a combinational stream read port.
REQ-029 The top level SHALL instantiate conv_mem_bank NUM_BANKS times.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
- Config write/read-back: write bank 2, addr 5 = 0xA5..A5; read bank 2, addr 5 -> cfg_rd_data_o = 0xA5..A5 one cycle later.
- Full stream, ready_i high: fill word = {bank, addr}; start_i at t -> beats at t+1..t+8 carry addresses 0..7; last_o only on address 7; busy_o falls at t+9.
- Backpressure: ready_i low for 3 cycles at beat 2 -> data_o stable for 3 cycles; all 8 beats delivered in order, none lost or duplicated.
- Invalid bank: write bank 6 -> no stored word changes; read bank 6 -> 0.
- Write during stream: write bank 0, addr 7 while the beat for addr 3 is valid -> addr 7 beat shows the new data.
- Reset mid-pass: rst_i at beat 4 -> valid_o = 0 and busy_o = 0 next cycle; memory intact; a new start_i restreams from address 0.

Source files
------------

// File: rtl/conv_mem_stream_pkg.sv
// -----------------------------------------------------------------------------
// conv_mem_stream_pkg
// Shared definitions for the convolution parameter memory streamer:
//   - stream FSM state encoding
//   - default conv1/conv2 memory geometry (5 banks: 3 weight taps, bias, shift;
//     8 words of 104 bits per bank)
// -----------------------------------------------------------------------------
package conv_mem_stream_pkg;

  // Stream FSM state encoding.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_e;

  // Default geometry shared by the conv1 and conv2 parameter memories.
  localparam int CONV_NUM_BANKS = 5;    // 3 weight taps + bias + shift
  localparam int CONV_BANK_BW   = 3;    // bank select width
  localparam int CONV_ADDR_BW   = 3;    // word address width (DEPTH = 8)
  localparam int CONV_VECTOR_BW = 104;  // bits per stored word

endpackage : conv_mem_stream_pkg

// File: rtl/conv_mem_bank.sv
// -----------------------------------------------------------------------------
// conv_mem_bank
// One bank of parameter storage: 2^ADDR_BW words of VECTOR_BW bits.
// The memory has no reset; its contents survive the streamer's reset.
//
// Ports
//   clk_i        : clock
//   wr_en_i      : write strobe, word committed at the next clock edge
//   wr_addr_i    : write word address
//   wr_data_i    : write data
//   rd_addr_i    : config read address (combinational read)
//   rd_data_o    : config read data (registered by the parent)
//   strm_addr_i  : stream read address (combinational read)
//   strm_data_o  : stream read data (registered by the parent)
//
// Both read ports are combinational and the write commits at the clock edge,
// so a read registered in the same cycle as a write to the same word captures
// the old contents (read-first).
// -----------------------------------------------------------------------------
module conv_mem_bank
  import conv_mem_stream_pkg::*;
#(
  parameter int ADDR_BW   = CONV_ADDR_BW,
  parameter int VECTOR_BW = CONV_VECTOR_BW
) (
  input  logic                 clk_i,
  input  logic                 wr_en_i,
  input  logic [ADDR_BW-1:0]   wr_addr_i,
  input  logic [VECTOR_BW-1:0] wr_data_i,
  input  logic [ADDR_BW-1:0]   rd_addr_i,
  output logic [VECTOR_BW-1:0] rd_data_o,
  input  logic [ADDR_BW-1:0]   strm_addr_i,
  output logic [VECTOR_BW-1:0] strm_data_o
);

  localparam int DEPTH = 1 << ADDR_BW;

  logic [VECTOR_BW-1:0] mem_q [DEPTH];

  // Storage write port; no reset so stored parameters persist across resets.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o   = mem_q[rd_addr_i];
  assign strm_data_o = mem_q[strm_addr_i];

endmodule : conv_mem_bank

// File: rtl/conv_mem_stream.sv
// -----------------------------------------------------------------------------
// conv_mem_stream
// Parameter memory of NUM_BANKS banks x DEPTH words with a config access port
// and a streaming read port. One stream pass emits DEPTH beats, each beat
// carrying all banks at one address, under a valid/ready handshake.
//
// Ports
//   clk_i             : clock
//   rst_i             : synchronous active-high reset (memory not affected)
//   cfg_wr_en_i       : config write strobe (never stalled, any state)
//   cfg_rd_en_i       : config read strobe (data one cycle later, then held)
//   cfg_rd_wr_bank_i  : config bank; banks >= NUM_BANKS are ignored / read 0
//   cfg_rd_wr_addr_i  : config word address
//   cfg_wr_data_i     : config write data
//   cfg_rd_data_o     : config read-back data
//   start_i           : start a stream pass (ignored while busy)
//   busy_o            : stream pass in progress
//   valid_o           : stream beat valid
//   ready_i           : downstream accepts the beat
//   data_o            : {bank NUM_BANKS-1 .. bank 0} at one address
//   last_o            : beat carries address DEPTH-1
// -----------------------------------------------------------------------------
module conv_mem_stream
  import conv_mem_stream_pkg::*;
#(
  parameter int NUM_BANKS = CONV_NUM_BANKS,
  parameter int BANK_BW   = CONV_BANK_BW,
  parameter int ADDR_BW   = CONV_ADDR_BW,
  parameter int VECTOR_BW = CONV_VECTOR_BW
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           cfg_wr_en_i,
  input  logic                           cfg_rd_en_i,
  input  logic [BANK_BW-1:0]             cfg_rd_wr_bank_i,
  input  logic [ADDR_BW-1:0]             cfg_rd_wr_addr_i,
  input  logic [VECTOR_BW-1:0]           cfg_wr_data_i,
  output logic [VECTOR_BW-1:0]           cfg_rd_data_o,
  input  logic                           start_i,
  output logic                           busy_o,
  output logic                           valid_o,
  input  logic                           ready_i,
  output logic [NUM_BANKS*VECTOR_BW-1:0] data_o,
  output logic                           last_o
);

  // Pointer is one bit wider than the address so "all DEPTH beats issued"
  // (PTR_END) cannot be confused with a wrap back to address 0.
  localparam logic [ADDR_BW:0]   PTR_ONE    = {{ADDR_BW{1'b0}}, 1'b1};
  localparam logic [ADDR_BW:0]   PTR_END    = {1'b1, {ADDR_BW{1'b0}}};
  localparam logic [ADDR_BW-1:0] LAST_ADDR  = {ADDR_BW{1'b1}};
  localparam logic [BANK_BW:0]   BANK_LIMIT = (BANK_BW+1)'(NUM_BANKS);

  state_e                         state_q, state_d;
  logic [ADDR_BW:0]               ptr_q, ptr_d;
  logic                           valid_q, valid_d;
  logic                           last_q, last_d;
  logic [NUM_BANKS*VECTOR_BW-1:0] data_q, data_d;
  logic [VECTOR_BW-1:0]           cfg_rd_data_q, cfg_rd_data_d;

  logic [VECTOR_BW-1:0]           cfg_rd_word_s [NUM_BANKS];
  logic [NUM_BANKS*VECTOR_BW-1:0] strm_vec_s;
  logic [ADDR_BW-1:0]             strm_addr_s;
  logic                           bank_ok_s;
  logic                           slot_free_s;
  logic                           beats_left_s;
  logic                           retire_last_s;

  assign bank_ok_s = ({1'b0, cfg_rd_wr_bank_i} < BANK_LIMIT);

  // In IDLE the stream port looks at address 0 so the first beat can be
  // loaded on the same edge that accepts start_i.
  assign strm_addr_s = (state_q == ST_STREAM) ? ptr_q[ADDR_BW-1:0]
                                              : {ADDR_BW{1'b0}};

  // Bank array; each bank's stream word lands in its slice of the beat.
  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    logic wr_en_s;

    // An out-of-range bank matches no instance, so such writes are dropped.
    assign wr_en_s = cfg_wr_en_i && (cfg_rd_wr_bank_i == BANK_BW'(g));

    conv_mem_bank #(
      .ADDR_BW   (ADDR_BW),
      .VECTOR_BW (VECTOR_BW)
    ) u_bank (
      .clk_i       (clk_i),
      .wr_en_i     (wr_en_s),
      .wr_addr_i   (cfg_rd_wr_addr_i),
      .wr_data_i   (cfg_wr_data_i),
      .rd_addr_i   (cfg_rd_wr_addr_i),
      .rd_data_o   (cfg_rd_word_s[g]),
      .strm_addr_i (strm_addr_s),
      .strm_data_o (strm_vec_s[g*VECTOR_BW +: VECTOR_BW])
    );
  end

  // Config read-back register: loads on a read strobe, otherwise holds.
  always_comb begin
    cfg_rd_data_d = cfg_rd_data_q;
    if (cfg_rd_en_i) begin
      if (bank_ok_s) begin
        cfg_rd_data_d = cfg_rd_word_s[cfg_rd_wr_bank_i];
      end else begin
        cfg_rd_data_d = {VECTOR_BW{1'b0}};
      end
    end else begin
      cfg_rd_data_d = cfg_rd_data_q;
    end
  end

  assign slot_free_s   = !valid_q || ready_i;
  assign beats_left_s  = (ptr_q != PTR_END);
  assign retire_last_s = valid_q && ready_i && last_q;

  // Stream FSM next-state and output-register next values.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    valid_d = valid_q;
    last_d  = last_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          // Pointer restarts at 0; beat 0 is issued immediately, so the
          // stored pointer already points at the next address.
          state_d = ST_STREAM;
          data_d  = strm_vec_s;
          valid_d = 1'b1;
          last_d  = (strm_addr_s == LAST_ADDR);
          ptr_d   = PTR_ONE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (retire_last_s) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
          last_d  = 1'b0;
        end else if (slot_free_s && beats_left_s) begin
          data_d  = strm_vec_s;
          valid_d = 1'b1;
          last_d  = (strm_addr_s == LAST_ADDR);
          ptr_d   = ptr_q + PTR_ONE;
        end else if (valid_q && ready_i) begin
          valid_d = 1'b0;
        end else begin
          // Backpressure or nothing to do: hold data, last and pointer.
          valid_d = valid_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      ptr_q         <= {(ADDR_BW+1){1'b0}};
      valid_q       <= 1'b0;
      last_q        <= 1'b0;
      data_q        <= {(NUM_BANKS*VECTOR_BW){1'b0}};
      cfg_rd_data_q <= {VECTOR_BW{1'b0}};
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      valid_q       <= valid_d;
      last_q        <= last_d;
      data_q        <= data_d;
      cfg_rd_data_q <= cfg_rd_data_d;
    end
  end

  assign busy_o        = (state_q == ST_STREAM);
  assign valid_o       = valid_q;
  assign last_o        = last_q;
  assign data_o        = data_q;
  assign cfg_rd_data_o = cfg_rd_data_q;

endmodule : conv_mem_stream

// File: tb/tb_conv_mem_stream.sv
// -----------------------------------------------------------------------------
// tb_conv_mem_stream
// Self-checking bench for conv_mem_stream. A plain array holds the expected
// memory contents; expected beats are the concatenation of all banks at the
// beat's address, which equals the beat index within a pass.
// -----------------------------------------------------------------------------
module tb_conv_mem_stream;

  localparam int NB    = 5;
  localparam int BBW   = 3;
  localparam int ABW   = 3;
  localparam int VBW   = 104;
  localparam int DEPTH = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              cfg_wr_en = 1'b0;
  logic              cfg_rd_en = 1'b0;
  logic [BBW-1:0]    bank = '0;
  logic [ABW-1:0]    addr = '0;
  logic [VBW-1:0]    wdata = '0;
  logic [VBW-1:0]    rdata;
  logic              start = 1'b0;
  logic              busy;
  logic              valid;
  logic              ready = 1'b0;
  logic [NB*VBW-1:0] data;
  logic              last;

  int total = 0;
  int bad   = 0;

  logic [VBW-1:0] mdl [NB][DEPTH];

  conv_mem_stream dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .cfg_wr_en_i      (cfg_wr_en),
    .cfg_rd_en_i      (cfg_rd_en),
    .cfg_rd_wr_bank_i (bank),
    .cfg_rd_wr_addr_i (addr),
    .cfg_wr_data_i    (wdata),
    .cfg_rd_data_o    (rdata),
    .start_i          (start),
    .busy_o           (busy),
    .valid_o          (valid),
    .ready_i          (ready),
    .data_o           (data),
    .last_o           (last)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [VBW-1:0] rnd_word();
    logic [127:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom()};
    return t[VBW-1:0];
  endfunction

  function automatic logic [NB*VBW-1:0] exp_beat(input int a);
    logic [NB*VBW-1:0] r;
    for (int b = 0; b < NB; b++) r[b*VBW +: VBW] = mdl[b][a];
    return r;
  endfunction

  task automatic cfg_write(input int b, input int a, input logic [VBW-1:0] d);
    cfg_wr_en = 1'b1; bank = BBW'(b); addr = ABW'(a); wdata = d;
    tick();
    cfg_wr_en = 1'b0;
    if (b < NB) mdl[b][a] = d;
  endtask

  task automatic cfg_read(input int b, input int a);
    cfg_rd_en = 1'b1; bank = BBW'(b); addr = ABW'(a);
    tick();
    cfg_rd_en = 1'b0;
  endtask

  task automatic fill_bank_addr();
    logic [VBW-1:0] w;
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < DEPTH; a++) begin
        w = '0;
        w[5:0] = {3'(b), 3'(a)};
        cfg_write(b, a, w);
      end
  endtask

  // mode 0: ready high; 1: ready low 3 cycles at beat 2; 2: random ready and
  // random start_i during the pass; 3: ready high, write bank0/addr7 at beat 3.
  task automatic run_pass(input int mode, input string tag);
    int beats = 0;
    int cyc = 0;
    int stall = 0;
    logic hold = 1'b0;
    logic [NB*VBW-1:0] pdata = '0;
    logic plast = 1'b0;
    logic pend = 1'b0;
    logic [VBW-1:0] nw = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (beats < DEPTH && cyc < 200) begin
      case (mode)
        1:       ready = !(beats == 2 && stall < 3);
        2:       begin ready = 1'($urandom_range(0, 1)); start = 1'($urandom_range(0, 1)); end
        default: ready = 1'b1;
      endcase
      if (mode == 3 && beats == 3 && valid && !pend) begin
        nw = rnd_word();
        cfg_wr_en = 1'b1; bank = 3'd0; addr = 3'd7; wdata = nw; pend = 1'b1;
      end
      total++;
      if (busy !== 1'b1) begin
        bad++; $display("FAIL %s busy: got %b want 1 (beat %0d)", tag, busy, beats);
      end
      if (hold) begin
        total++;
        if (data !== pdata || last !== plast || valid !== 1'b1) begin
          bad++; $display("FAIL %s hold: data/last/valid changed under backpressure (beat %0d)", tag, beats);
        end
      end
      if (valid) begin
        total++;
        if (data !== exp_beat(beats) || last !== (beats == DEPTH - 1)) begin
          bad++;
          $display("FAIL %s beat%0d: got last=%b data=%h want last=%b data=%h", tag, beats, last, data,
                   (beats == DEPTH - 1), exp_beat(beats));
        end
      end else if (mode == 0 || mode == 3) begin
        total++; bad++;
        $display("FAIL %s gap: valid=0 want 1 at beat %0d", tag, beats);
      end
      hold  = valid && !ready;
      pdata = data;
      plast = last;
      if (valid && !ready) stall++;
      if (valid && ready) beats++;
      tick();
      cyc++;
      cfg_wr_en = 1'b0;
      if (pend && cfg_wr_en == 1'b0 && mdl[0][7] !== nw) mdl[0][7] = nw;
    end
    start = 1'b0;
    total++;
    if (beats != DEPTH) begin
      bad++; $display("FAIL %s count: got %0d beats want %0d", tag, beats, DEPTH);
    end
    total++;
    if (busy !== 1'b0 || valid !== 1'b0 || last !== 1'b0) begin
      bad++; $display("FAIL %s end: busy=%b valid=%b last=%b want 0 0 0", tag, busy, valid, last);
    end
    if (mode == 0 || mode == 3) begin
      total++;
      if (cyc != DEPTH) begin
        bad++; $display("FAIL %s cycles: got %0d want %0d", tag, cyc, DEPTH);
      end
    end
    if (mode == 1) begin
      total++;
      if (stall != 3) begin
        bad++; $display("FAIL %s stalls: got %0d want 3", tag, stall);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    total++;
    if (valid !== 1'b0 || busy !== 1'b0 || last !== 1'b0) begin
      bad++; $display("FAIL reset_ctl: valid=%b busy=%b last=%b want 0 0 0", valid, busy, last);
    end
    total++;
    if (data !== '0 || rdata !== '0) begin
      bad++; $display("FAIL reset_data: data=%h rdata=%h want 0", data, rdata);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_cfg_rw();
    logic [VBW-1:0] a5 = {13{8'hA5}};
    logic [VBW-1:0] old;
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < DEPTH; a++) cfg_write(b, a, rnd_word());
    cfg_write(2, 5, a5);
    cfg_read(2, 5);
    total++;
    if (rdata !== a5) begin
      bad++; $display("FAIL cfg_read: got %h want %h", rdata, a5);
    end
    cfg_write(2, 5, rnd_word());
    total++;
    if (rdata !== a5) begin
      bad++; $display("FAIL cfg_hold: got %h want %h", rdata, a5);
    end
    // same-cycle read and write of one word returns the old contents
    old = mdl[1][3];
    cfg_rd_en = 1'b1;
    cfg_write(1, 3, rnd_word());
    cfg_rd_en = 1'b0;
    total++;
    if (rdata !== old) begin
      bad++; $display("FAIL read_first: got %h want %h", rdata, old);
    end
    for (int i = 0; i < 6; i++) begin
      int b = $urandom_range(0, NB - 1);
      int a = $urandom_range(0, DEPTH - 1);
      cfg_read(b, a);
      total++;
      if (rdata !== mdl[b][a]) begin
        bad++; $display("FAIL cfg_rand b%0d a%0d: got %h want %h", b, a, rdata, mdl[b][a]);
      end
    end
  endtask

  task automatic test_invalid_bank();
    cfg_write(6, 2, rnd_word());
    cfg_write(5, 7, rnd_word());
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < DEPTH; a++) begin
        cfg_read(b, a);
        total++;
        if (rdata !== mdl[b][a]) begin
          bad++; $display("FAIL inv_intact b%0d a%0d: got %h want %h", b, a, rdata, mdl[b][a]);
        end
      end
    for (int b = NB; b < 8; b++) begin
      cfg_read(b, 2);
      total++;
      if (rdata !== '0) begin
        bad++; $display("FAIL inv_read b%0d: got %h want 0", b, rdata);
      end
    end
  endtask

  task automatic test_full_stream();
    fill_bank_addr();
    run_pass(0, "full");
  endtask

  task automatic test_backpressure();
    run_pass(1, "bp");
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 6; k++) cfg_write($urandom_range(0, NB - 1), $urandom_range(0, DEPTH - 1), rnd_word());
      run_pass(2, "bp_rand");
    end
  endtask

  task automatic test_write_during_stream();
    run_pass(3, "wr_strm");
  endtask

  task automatic test_reset_mid_pass();
    ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    total++;
    if (valid !== 1'b1 || data !== exp_beat(4)) begin
      bad++; $display("FAIL rst_mid_beat4: valid=%b data=%h want 1 %h", valid, data, exp_beat(4));
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL rst_mid_abort: valid=%b busy=%b want 0 0", valid, busy);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (valid !== 1'b0 || busy !== 1'b0) begin
        bad++; $display("FAIL rst_mid_quiet: valid=%b busy=%b want 0 0", valid, busy);
      end
    end
    run_pass(0, "rst_restream");
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 8; k++) cfg_write($urandom_range(0, NB - 1), $urandom_range(0, DEPTH - 1), rnd_word());
    run_pass(0, "b2b_a");
    run_pass(0, "b2b_b");
    run_pass(2, "b2b_c");
  endtask

  initial begin
    test_reset();
    test_cfg_rw();
    test_invalid_bank();
    test_full_stream();
    test_backpressure();
    test_write_during_stream();
    test_reset_mid_pass();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_conv_mem_stream
